// File: rtl/arrhythmia_result_buffer.sv
// arrhythmia_result_buffer
//
// Sits behind the arrhythmia inference top level. It captures the two
// sigmoid class scores on each rising edge of done_in and works out the
// class decision, the winning score, the score margin and a
// low-confidence flag. Each result is queued in a first-word
// fall-through FIFO that the host drains with valid/ready. Saturating
// counts of beats and abnormal beats are kept alongside the queue.
//
// Ports
//   clk            clock; all state changes on posedge
//   reset          asynchronous active-low reset
//   y_in           {class1, class0} scores, sign-magnitude, BITSIZE each
//   done_in        inference-complete level from the controller
//   clear          synchronous clear of counters, overflow and sequence number
//   out_valid      FIFO head valid
//   out_ready      consumer accepts the head entry
//   out_class      winning class of the head entry (1 = arrhythmia)
//   out_prob       winning raw score of the head entry
//   out_margin     |class1 - class0|, saturated, sign bit always 0
//   out_lowconf    out_margin below MARGIN_TH
//   out_seq        sequence number of the head entry
//   overflow       sticky: a result was dropped because the FIFO was full
//   beat_count     detected inferences, saturating
//   abnormal_count detections with class 1, saturating
module arrhythmia_result_buffer #(
  parameter int                 BITSIZE   = 16,
  parameter int                 DEPTH     = 4,
  parameter logic [BITSIZE-1:0] MARGIN_TH = 16'h0100,
  parameter int                 SEQW      = 8,
  parameter int                 CNTW      = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [2*BITSIZE-1:0]   y_in,
  input  logic                   done_in,
  input  logic                   clear,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_class,
  output logic [BITSIZE-1:0]     out_prob,
  output logic [BITSIZE-1:0]     out_margin,
  output logic                   out_lowconf,
  output logic [SEQW-1:0]        out_seq,
  output logic                   overflow,
  output logic [CNTW-1:0]        beat_count,
  output logic [CNTW-1:0]        abnormal_count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [BITSIZE-1:0] TH_MAG = {1'b0, MARGIN_TH[BITSIZE-2:0]};
  localparam logic [BITSIZE-1:0] MAX_MAG = {1'b0, {(BITSIZE-1){1'b1}}};

  typedef struct packed {
    logic               cls;
    logic [BITSIZE-1:0] prob;
    logic [BITSIZE-1:0] margin;
    logic               lowconf;
    logic [SEQW-1:0]    seq;
  } result_t;

  // Sign-magnitude to two's complement, one bit wider so the most
  // negative magnitude still fits. Both encodings of zero map to 0.
  function automatic logic signed [BITSIZE:0] to_twos(input logic [BITSIZE-1:0] w);
    logic signed [BITSIZE:0] mag;
    mag = signed'({2'b00, w[BITSIZE-2:0]});
    return w[BITSIZE-1] ? -mag : mag;
  endfunction

  // Absolute difference clamped to the largest positive datapath magnitude.
  function automatic logic [BITSIZE-1:0] sat_margin(input logic signed [BITSIZE+1:0] d);
    logic [BITSIZE+1:0] a;
    a = d[BITSIZE+1] ? unsigned'(-d) : unsigned'(d);
    if (a > {2'b00, MAX_MAG}) return MAX_MAG;
    return a[BITSIZE-1:0];
  endfunction

  // ---------------- p0: rising-edge detect on done_in ----------------
  logic            done_prev;
  logic            detect_p0;
  logic [SEQW-1:0] seq_cnt;
  logic [SEQW-1:0] seq_p0;

  assign detect_p0 = done_in & ~done_prev;
  // A clear on the capture edge restarts numbering at this entry.
  assign seq_p0    = clear ? '0 : seq_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      done_prev <= 1'b1;
      seq_cnt   <= '0;
    end else begin
      done_prev <= done_in;
      if (clear)
        seq_cnt <= detect_p0 ? SEQW'(1) : '0;
      else if (detect_p0)
        seq_cnt <= seq_cnt + SEQW'(1);
    end
  end

  // ---------------- p1: captured scores ----------------
  logic                 vld_p1;
  logic [BITSIZE-1:0]   y0_p1;
  logic [BITSIZE-1:0]   y1_p1;
  logic [SEQW-1:0]      seq_p1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) vld_p1 <= 1'b0;
    else        vld_p1 <= detect_p0;
  end

  always_ff @(posedge clk) begin
    if (detect_p0) begin
      y0_p1  <= y_in[BITSIZE-1:0];
      y1_p1  <= y_in[2*BITSIZE-1:BITSIZE];
      seq_p1 <= seq_p0;
    end
  end

  // Decision logic evaluated on the p1 contents.
  logic signed [BITSIZE:0]   c0_p1;
  logic signed [BITSIZE:0]   c1_p1;
  logic signed [BITSIZE+1:0] diff_p1;
  result_t                   res_p1;

  always_comb begin
    c0_p1          = to_twos(y0_p1);
    c1_p1          = to_twos(y1_p1);
    diff_p1        = {c1_p1[BITSIZE], c1_p1} - {c0_p1[BITSIZE], c0_p1};
    res_p1         = '0;
    res_p1.cls     = (c1_p1 > c0_p1);
    res_p1.prob    = res_p1.cls ? y1_p1 : y0_p1;
    res_p1.margin  = sat_margin(diff_p1);
    res_p1.lowconf = (res_p1.margin < TH_MAG);
    res_p1.seq     = seq_p1;
  end

  // Statistics count every classified beat, even if the FIFO later drops it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      beat_count     <= '0;
      abnormal_count <= '0;
    end else if (clear) begin
      beat_count     <= '0;
      abnormal_count <= '0;
    end else if (vld_p1) begin
      if (beat_count != '1)
        beat_count <= beat_count + CNTW'(1);
      if (res_p1.cls && (abnormal_count != '1))
        abnormal_count <= abnormal_count + CNTW'(1);
    end
  end

  // ---------------- p2: classified result awaiting FIFO push ----------------
  logic    vld_p2;
  result_t res_p2;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) vld_p2 <= 1'b0;
    else        vld_p2 <= vld_p1;
  end

  always_ff @(posedge clk) begin
    if (vld_p1) res_p2 <= res_p1;
  end

  // ---------------- result FIFO ----------------
  result_t       mem [DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic [AW:0]   fill;
  logic          full;
  logic          pop;
  logic          write;
  result_t       head;

  assign fill      = wr_ptr - rd_ptr;
  assign full      = (fill == (AW+1)'(DEPTH));
  assign out_valid = (wr_ptr != rd_ptr);
  assign pop       = out_valid & out_ready;
  // A pop on the same edge frees the slot the push needs.
  assign write     = vld_p2 & (~full | pop);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (write) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)   rd_ptr <= rd_ptr + (AW+1)'(1);
      if (clear)
        overflow <= 1'b0;
      else if (vld_p2 && full && !pop)
        overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (write) mem[wr_ptr[AW-1:0]] <= res_p2;
  end

  // Head fields read as zero whenever the queue is empty.
  assign head        = out_valid ? mem[rd_ptr[AW-1:0]] : '0;
  assign out_class   = head.cls;
  assign out_prob    = head.prob;
  assign out_margin  = head.margin;
  assign out_lowconf = head.lowconf;
  assign out_seq     = head.seq;

endmodule

// File: tb/tb_arrhythmia_result_buffer.sv
module tb_arrhythmia_result_buffer;

  logic        clk;
  logic        reset;
  logic [31:0] y_in;
  logic        done_in;
  logic        clear;
  logic        out_ready;

  logic        out_valid;
  logic        out_class;
  logic [15:0] out_prob;
  logic [15:0] out_margin;
  logic        out_lowconf;
  logic [7:0]  out_seq;
  logic        overflow;
  logic [15:0] beat_count;
  logic [15:0] abnormal_count;

  logic        s_valid;
  logic        s_class;
  logic [15:0] s_prob;
  logic [15:0] s_margin;
  logic        s_lowconf;
  logic [7:0]  s_seq;
  logic        s_overflow;
  logic [3:0]  s_beat;
  logic [3:0]  s_abn;

  int total = 0;
  int bad   = 0;

  arrhythmia_result_buffer dut (
    .clk(clk), .reset(reset), .y_in(y_in), .done_in(done_in), .clear(clear),
    .out_valid(out_valid), .out_ready(out_ready), .out_class(out_class),
    .out_prob(out_prob), .out_margin(out_margin), .out_lowconf(out_lowconf),
    .out_seq(out_seq), .overflow(overflow), .beat_count(beat_count),
    .abnormal_count(abnormal_count)
  );

  // Narrow-counter instance so saturation is reachable in a short run.
  arrhythmia_result_buffer #(.CNTW(4)) sat_dut (
    .clk(clk), .reset(reset), .y_in(y_in), .done_in(done_in), .clear(clear),
    .out_valid(s_valid), .out_ready(out_ready), .out_class(s_class),
    .out_prob(s_prob), .out_margin(s_margin), .out_lowconf(s_lowconf),
    .out_seq(s_seq), .overflow(s_overflow), .beat_count(s_beat),
    .abnormal_count(s_abn)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called at a negedge; detect edge is the next posedge, returns one
  // negedge after the following (S2) edge.
  task automatic pulse(input logic [15:0] y0, input logic [15:0] y1);
    y_in    = {y1, y0};
    done_in = 1'b1;
    @(negedge clk);
    done_in = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0; done_in = 1'b0; clear = 1'b0; out_ready = 1'b0; y_in = '0;
    tick(2);
    reset = 1'b1;
    tick(1);
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b0; done_in = 1'b1; clear = 1'b0; out_ready = 1'b0;
    y_in = {16'h0600, 16'h0400};
    tick(1);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b expected 0", out_valid); end
    total++; if ({out_class, out_prob, out_margin, out_lowconf, out_seq} !== 42'd0) begin bad++; $display("FAIL rst_fields: got %h expected 0", {out_class, out_prob, out_margin, out_lowconf, out_seq}); end
    total++; if ({overflow, beat_count, abnormal_count} !== 33'd0) begin bad++; $display("FAIL rst_stats: got %h expected 0", {overflow, beat_count, abnormal_count}); end
    reset = 1'b1;
    tick(10);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL held_done_valid: got %b expected 0", out_valid); end
    total++; if (beat_count !== 16'd0) begin bad++; $display("FAIL held_done_beats: got %0d expected 0", beat_count); end
    done_in = 1'b0;
    tick(1);
    done_in = 1'b1;
    tick(1);
    done_in = 1'b0;
    tick(1);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL latency_early: got %b expected 0", out_valid); end
    tick(1);
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL latency_valid: got %b expected 1", out_valid); end
    total++; if (out_seq !== 8'd0 || beat_count !== 16'd1) begin bad++; $display("FAIL first_entry: got seq=%0d beats=%0d expected seq=0 beats=1", out_seq, beat_count); end
  endtask

  task automatic test_decision();
    logic [15:0] t_y0 [6];
    logic [15:0] t_y1 [6];
    logic        t_cls [6];
    logic [15:0] t_prob [6];
    logic [15:0] t_mar [6];
    logic        t_lc [6];
    t_y0[0] = 16'h0400; t_y1[0] = 16'h0600; t_cls[0] = 1; t_prob[0] = 16'h0600; t_mar[0] = 16'h0200; t_lc[0] = 0;
    t_y0[1] = 16'h0480; t_y1[1] = 16'h0400; t_cls[1] = 0; t_prob[1] = 16'h0480; t_mar[1] = 16'h0080; t_lc[1] = 1;
    t_y0[2] = 16'h0300; t_y1[2] = 16'h0300; t_cls[2] = 0; t_prob[2] = 16'h0300; t_mar[2] = 16'h0000; t_lc[2] = 1;
    t_y0[3] = 16'h8000; t_y1[3] = 16'h0000; t_cls[3] = 0; t_prob[3] = 16'h8000; t_mar[3] = 16'h0000; t_lc[3] = 1;
    t_y0[4] = 16'h8200; t_y1[4] = 16'h0100; t_cls[4] = 1; t_prob[4] = 16'h0100; t_mar[4] = 16'h0300; t_lc[4] = 0;
    t_y0[5] = 16'hFFFF; t_y1[5] = 16'h7FFF; t_cls[5] = 1; t_prob[5] = 16'h7FFF; t_mar[5] = 16'h7FFF; t_lc[5] = 0;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      pulse(t_y0[i], t_y1[i]);
      tick(1);
      total++;
      if (out_valid !== 1'b1 || out_class !== t_cls[i] || out_prob !== t_prob[i] ||
          out_margin !== t_mar[i] || out_lowconf !== t_lc[i] || out_seq !== 8'(i)) begin
        bad++;
        $display("FAIL decision_%0d: got v=%b c=%b p=%h m=%h lc=%b seq=%0d expected v=1 c=%b p=%h m=%h lc=%b seq=%0d",
                 i, out_valid, out_class, out_prob, out_margin, out_lowconf, out_seq,
                 t_cls[i], t_prob[i], t_mar[i], t_lc[i], i);
      end
      if (i == 0) begin
        total++; if (abnormal_count !== 16'd1) begin bad++; $display("FAIL abnormal_first: got %0d expected 1", abnormal_count); end
      end
      out_ready = 1'b1;
      tick(1);
      out_ready = 1'b0;
    end
    total++; if (beat_count !== 16'd6 || abnormal_count !== 16'd3) begin bad++; $display("FAIL decision_counts: got beats=%0d abn=%0d expected 6 3", beat_count, abnormal_count); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL decision_drained: got %b expected 0", out_valid); end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < 6; i++) pulse(16'h0400, 16'h0300);
    tick(2);
    total++; if (out_valid !== 1'b1 || out_seq !== 8'd0) begin bad++; $display("FAIL ovf_head: got v=%b seq=%0d expected v=1 seq=0", out_valid, out_seq); end
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_flag: got %b expected 1", overflow); end
    total++; if (beat_count !== 16'd6) begin bad++; $display("FAIL ovf_beats: got %0d expected 6", beat_count); end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      total++; if (out_valid !== 1'b1 || out_seq !== 8'(i)) begin bad++; $display("FAIL ovf_drain_%0d: got v=%b seq=%0d expected v=1 seq=%0d", i, out_valid, out_seq, i); end
      tick(1);
    end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL ovf_empty: got %b expected 0", out_valid); end
    out_ready = 1'b0;
  endtask

  task automatic test_full_pop();
    do_reset();
    for (int i = 0; i < 4; i++) pulse(16'h0100, 16'h0200);
    pulse(16'h0100, 16'h0200);
    out_ready = 1'b1;
    tick(1);
    out_ready = 1'b0;
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL fullpop_ovf: got %b expected 0", overflow); end
    out_ready = 1'b1;
    for (int i = 1; i < 5; i++) begin
      total++; if (out_valid !== 1'b1 || out_seq !== 8'(i)) begin bad++; $display("FAIL fullpop_drain_%0d: got v=%b seq=%0d expected v=1 seq=%0d", i, out_valid, out_seq, i); end
      tick(1);
    end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL fullpop_count: got %b expected 0 after 4 pops", out_valid); end
    out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic       e_cls [3];
    logic [15:0] e_prob [3];
    do_reset();
    out_ready = 1'b1;
    pulse(16'h0000, 16'h0100);
    tick(1);
    total++; if (out_valid !== 1'b1 || out_seq !== 8'd0) begin bad++; $display("FAIL empty_push_ready: got v=%b seq=%0d expected v=1 seq=0", out_valid, out_seq); end
    tick(1);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL empty_push_pop: got %b expected 0", out_valid); end
    out_ready = 1'b0;
    e_cls[0] = 1; e_prob[0] = 16'h0100;
    e_cls[1] = 0; e_prob[1] = 16'h0100;
    e_cls[2] = 1; e_prob[2] = 16'h0200;
    pulse(16'h0000, 16'h0100);
    pulse(16'h0100, 16'h0000);
    pulse(16'h0000, 16'h0200);
    tick(1);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      total++;
      if (out_valid !== 1'b1 || out_seq !== 8'(i + 1) || out_class !== e_cls[i] || out_prob !== e_prob[i]) begin
        bad++;
        $display("FAIL b2b_%0d: got v=%b seq=%0d c=%b p=%h expected v=1 seq=%0d c=%b p=%h",
                 i, out_valid, out_seq, out_class, out_prob, i + 1, e_cls[i], e_prob[i]);
      end
      tick(1);
    end
    out_ready = 1'b0;
    total++; if (overflow !== 1'b0 || beat_count !== 16'd4) begin bad++; $display("FAIL b2b_stats: got ovf=%b beats=%0d expected 0 4", overflow, beat_count); end
  endtask

  task automatic test_saturation_clear();
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 15; i++) pulse(16'h0000, 16'h0100);
    tick(2);
    total++; if (s_beat !== 4'hF || s_abn !== 4'hF) begin bad++; $display("FAIL sat_reach: got beats=%h abn=%h expected F F", s_beat, s_abn); end
    pulse(16'h0000, 16'h0100);
    tick(2);
    total++; if (s_beat !== 4'hF || s_abn !== 4'hF) begin bad++; $display("FAIL sat_hold: got beats=%h abn=%h expected F F", s_beat, s_abn); end
    total++; if (beat_count !== 16'd16 || abnormal_count !== 16'd16) begin bad++; $display("FAIL wide_counts: got beats=%0d abn=%0d expected 16 16", beat_count, abnormal_count); end
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) pulse(16'h0000, 16'h0100);
    tick(2);
    total++; if (overflow !== 1'b1 || out_seq !== 8'd16) begin bad++; $display("FAIL preclear: got ovf=%b seq=%0d expected 1 16", overflow, out_seq); end
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    total++; if (beat_count !== 16'd0 || abnormal_count !== 16'd0 || overflow !== 1'b0) begin bad++; $display("FAIL clear_stats: got beats=%0d abn=%0d ovf=%b expected 0 0 0", beat_count, abnormal_count, overflow); end
    total++; if (out_valid !== 1'b1 || out_seq !== 8'd16) begin bad++; $display("FAIL clear_keeps_fifo: got v=%b seq=%0d expected 1 16", out_valid, out_seq); end
    out_ready = 1'b1;
    tick(4);
    out_ready = 1'b0;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL clear_drain: got %b expected 0", out_valid); end
    pulse(16'h0000, 16'h0100);
    tick(1);
    total++; if (out_seq !== 8'd0 || beat_count !== 16'd1) begin bad++; $display("FAIL seq_restart: got seq=%0d beats=%0d expected 0 1", out_seq, beat_count); end
    out_ready = 1'b1;
    tick(1);
    out_ready = 1'b0;
    // clear coincident with a detect edge
    y_in = {16'h0100, 16'h0000};
    done_in = 1'b1;
    clear = 1'b1;
    tick(1);
    done_in = 1'b0;
    clear = 1'b0;
    tick(2);
    total++; if (out_valid !== 1'b1 || out_seq !== 8'd0 || beat_count !== 16'd1) begin bad++; $display("FAIL clear_detect: got v=%b seq=%0d beats=%0d expected 1 0 1", out_valid, out_seq, beat_count); end
    out_ready = 1'b1;
    tick(1);
    out_ready = 1'b0;
    pulse(16'h0000, 16'h0100);
    tick(1);
    total++; if (out_seq !== 8'd1 || beat_count !== 16'd2) begin bad++; $display("FAIL clear_detect_next: got seq=%0d beats=%0d expected 1 2", out_seq, beat_count); end
  endtask

  initial begin
    reset = 1'b0; done_in = 1'b0; clear = 1'b0; out_ready = 1'b0; y_in = '0;
    test_reset();
    test_decision();
    test_overflow();
    test_full_pop();
    test_back_to_back();
    test_saturation_clear();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
